cfg_mgmt_target: RTL
====================

Name: cfg_mgmt_target

Overview:
- Responder end of the cfg_mgmt configuration-access port.
- Services single-outstanding read/write requests against a local DEPTH-dword configuration register file.
- Returns read data and a one-cycle done pulse after a programmable latency.
- Used as the config-space target behind the user-side config initiator, so regrw self-tests run without the hard PCIe core. Also provides access counters and a sticky protocol-error flag.

Parameters:
- DEPTH, 64, implemented dwords (power of 2, 16..1024); accesses at or beyond DEPTH are out of range.
- RSP_LAT, 3, cycles from request acceptance to done (1..15).
- INIT_00, 32'h0000_1172, reset value of dword 0 (device/vendor ID).
- INIT_3C, 32'h0000_01FF, reset value of dword 15 (byte offset 0x3C: int pin = 1, int line = 0xFF).

Ports:
- usr_clk  in  1  clock
- usr_rst  in  1  asynchronous active-high reset
- cfg_mgmt_addr_i  in  19  byte address; bits[1:0] ignored; dword index = addr[18:2]
- cfg_mgmt_write_i  in  1  write request level, held until done
- cfg_mgmt_write_data_i  in  32  write data
- cfg_mgmt_byte_enable_i  in  4  per-byte write enable, active-high, bit n -> data[8n+7:8n]
- cfg_mgmt_read_i  in  1  read request level, held until done
- cfg_mgmt_type1_cfg_reg_access_i  in  1  type-1 access qualifier
- cfg_mgmt_read_data_o  out  32  read data, valid with done
- cfg_mgmt_read_write_done_o  out  1  one-cycle completion pulse
- rd_cnt_o  out  16  completed reads, wraps 0xFFFF->0
- wr_cnt_o  out  16  completed writes, wraps
- proto_err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (asynchronous, usr_rst=1):
  - State IDLE.
  - All outputs 0.
  - Counters 0.
  - Register file: dword0=INIT_00, dword15=INIT_3C, all others 0.
- FSM states: IDLE, WAIT, DONE, HOLD.
- IDLE:
  - If read_i or write_i is sampled high, latch addr, data, byte enables, op and type1.
  - Load lat_cnt = RSP_LAT-1 and go to WAIT.
  - If read_i and write_i are both high, set proto_err_o and treat the access as a read.
- WAIT:
  - If the latched request level drops (abort): return to IDLE; no commit, no done, no count.
  - Else if lat_cnt == 0, go to DONE; otherwise decrement lat_cnt.
- DONE (exactly one cycle):
  - done_o = 1.
  - Read: read_data_o = register value, or 0 if out of range or type1=1; read_data_o holds until the next read completes; rd_cnt_o += 1.
  - Write: commit enabled bytes under the write mask; wr_cnt_o += 1.
  - Next state HOLD.
- HOLD: wait until read_i = 0 and write_i = 0, then IDLE. A request still high here is not re-accepted.
- Latency: request first sampled high at edge t -> done_o high in cycle t+RSP_LAT.
  - RSP_LAT = 1: WAIT is skipped; go directly IDLE -> DONE.
- Write mask:
  - Dwords 0..14: read-only, except dword1 bytes 0-1 (command), which are writable.
  - Dword15: byte0 writable only.
  - Dwords 16..DEPTH-1: fully writable.
  - Out of range: writes ignored, done still returned.
  - type1 = 1: write ignored, done returned, proto_err_o set.
  - byte_enable = 0: no bytes change, done returned, counted.
- proto_err_o clears only on reset.
- A request arriving while in DONE or HOLD is not a new access.
- Reset mid-access: immediate return to IDLE; no done pulse is emitted.

Test Plan:
- Reset, then read addr 60, RSP_LAT = 3 -> done is a single pulse 3 cycles after request; read_data_o = 0x0000_01FF; rd_cnt_o = 1.
- Write addr 60, data 0xA5A5_A5A5, be = 4'hF -> then read 60 returns 0x0000_01A5; wr_cnt_o = 1.
- Write addr 64 (dword16), data 0x1234_5678, be = 4'b0101 -> read returns 0x0034_0078; a write with be = 0 leaves the value unchanged and still returns done.
- Read and write asserted together on addr 0 -> treated as a read returning 0x0000_1172; proto_err_o = 1 and stays set; dword0 unchanged.
- Read request dropped after 1 cycle in WAIT -> no done; rd_cnt_o unchanged; FSM back in IDLE; next read completes normally.
- Read addr 0x1_0000 (out of range) and a type1 read -> read_data_o = 0 with done; assert usr_rst mid-WAIT -> no done; registers at init values.

Source files
------------

// File: rtl/cfg_mgmt_target.sv
// cfg_mgmt responder: single-outstanding read/write access to a local dword
// register file, with a programmable completion latency, access counters and a sticky error flag.
module cfg_mgmt_target #(
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned RSP_LAT = 3,
   parameter logic [31:0] INIT_00 = 32'h0000_1172,
   parameter logic [31:0] INIT_3C = 32'h0000_01FF
) (
   input  logic        usr_clk,
   input  logic        usr_rst,
   input  logic [18:0] cfg_mgmt_addr_i,
   input  logic        cfg_mgmt_write_i,
   input  logic [31:0] cfg_mgmt_write_data_i,
   input  logic [3:0]  cfg_mgmt_byte_enable_i,
   input  logic        cfg_mgmt_read_i,
   input  logic        cfg_mgmt_type1_cfg_reg_access_i,
   output logic [31:0] cfg_mgmt_read_data_o,
   output logic        cfg_mgmt_read_write_done_o,
   output logic [15:0] rd_cnt_o,
   output logic [15:0] wr_cnt_o,
   output logic        proto_err_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned IW = 17;
   localparam int unsigned LW = 4;

   typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} state_t;

   typedef struct packed {
      logic [IW-1:0] idx;
      logic [31:0]   data;
      logic [3:0]    be;
      logic          rd;
      logic          type1;
   } req_t;

   state_t        state_q, state_d;
   logic [LW-1:0] lat_q, lat_d;
   req_t          req_q, req_in_c, acc_c;
   logic [31:0]   regs [DEPTH];
   logic          any_req_c, enter_done_c, in_range_c, wr_commit_c;
   logic [31:0]   rd_val_c, wmask_c;
   logic          unused_addr_lsb;

   assign unused_addr_lsb = ^cfg_mgmt_addr_i[1:0];
   assign any_req_c       = cfg_mgmt_read_i | cfg_mgmt_write_i;

   // Byte lanes the register map allows software to change
   function automatic logic [31:0] map_mask_f(input logic [IW-1:0] idx);
      if (idx >= IW'(16))      return '1;
      else if (idx == IW'(1))  return 32'h0000_FFFF;
      else if (idx == IW'(15)) return 32'h0000_00FF;
      else                     return '0;
   endfunction

   // Next state; with RSP_LAT=1 the access completes straight from IDLE, so the live request is used
   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      req_in_c.idx   = cfg_mgmt_addr_i[18:2];
      req_in_c.data  = cfg_mgmt_write_data_i;
      req_in_c.be    = cfg_mgmt_byte_enable_i;
      req_in_c.rd    = cfg_mgmt_read_i;
      req_in_c.type1 = cfg_mgmt_type1_cfg_reg_access_i;
      acc_c = (state_q == IDLE) ? req_in_c : req_q;
      case (state_q)
         IDLE: begin
            if (any_req_c) begin
               lat_d   = LW'(RSP_LAT - 1);
               state_d = (RSP_LAT == 1) ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (!(req_q.rd ? cfg_mgmt_read_i : cfg_mgmt_write_i)) state_d = IDLE;
            else if (lat_q == '0)                                  state_d = DONE;
            else                                                   lat_d   = lat_q - LW'(1);
         end
         DONE:    state_d = HOLD;
         HOLD:    if (!any_req_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign enter_done_c = (state_d == DONE);
   assign in_range_c   = (acc_c.idx < IW'(DEPTH));
   assign rd_val_c     = (in_range_c && !acc_c.type1) ? regs[acc_c.idx[AW-1:0]] : '0;
   assign wr_commit_c  = enter_done_c && !acc_c.rd && in_range_c && !acc_c.type1;
   assign wmask_c      = map_mask_f(acc_c.idx) &
                         {{8{acc_c.be[3]}}, {8{acc_c.be[2]}}, {8{acc_c.be[1]}}, {8{acc_c.be[0]}}};

   // Control state, completion outputs and counters
   always_ff @(posedge usr_clk or posedge usr_rst) begin
      if (usr_rst) begin
         state_q                    <= IDLE;
         lat_q                      <= '0;
         req_q                      <= '0;
         cfg_mgmt_read_data_o       <= '0;
         cfg_mgmt_read_write_done_o <= 1'b0;
         rd_cnt_o                   <= '0;
         wr_cnt_o                   <= '0;
         proto_err_o                <= 1'b0;
      end else begin
         state_q                    <= state_d;
         lat_q                      <= lat_d;
         cfg_mgmt_read_write_done_o <= enter_done_c;
         if (state_q == IDLE && any_req_c) req_q <= req_in_c;
         if (state_q == IDLE && cfg_mgmt_read_i && cfg_mgmt_write_i) proto_err_o <= 1'b1;
         if (enter_done_c) begin
            if (acc_c.rd) begin
               cfg_mgmt_read_data_o <= rd_val_c;
               rd_cnt_o             <= rd_cnt_o + 16'd1;
            end else begin
               wr_cnt_o <= wr_cnt_o + 16'd1;
               if (acc_c.type1) proto_err_o <= 1'b1;
            end
         end
      end
   end

   // Register file with masked byte-lane commit
   always_ff @(posedge usr_clk or posedge usr_rst) begin
      if (usr_rst) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            regs[AW'(i)] <= (i == 0) ? INIT_00 : (i == 15) ? INIT_3C : '0;
      end else if (wr_commit_c) begin
         regs[acc_c.idx[AW-1:0]] <= (regs[acc_c.idx[AW-1:0]] & ~wmask_c) | (acc_c.data & wmask_c);
      end
   end

endmodule
